// File: rtl/biu_burst_addrgen_pkg.sv
// Shared BIU request types plus burst helpers for the burst address generator
// and the bus-master address-phase logic.
package biu_burst_addrgen_pkg;

  localparam int unsigned MAX_BURST_BEATS = 16;

  typedef enum logic [2:0] {
    BYTE       = 3'd0,
    HWORD      = 3'd1,
    WORD       = 3'd2,
    DWORD      = 3'd3,
    QWORD      = 3'd4,
    UNDEF_SIZE = 3'd7
  } biu_size_t;

  typedef enum logic [3:0] {
    SINGLE      = 4'd0,
    INCR        = 4'd1,
    WRAP4       = 4'd2,
    INCR4       = 4'd3,
    WRAP8       = 4'd4,
    INCR8       = 4'd5,
    WRAP16      = 4'd6,
    INCR16      = 4'd7,
    UNDEF_BURST = 4'd15
  } biu_type_t;

  // bit0 privileged, bit1 non-secure, bit2 instruction fetch
  typedef enum logic [2:0] {
    PROT_D_USR    = 3'b000,
    PROT_D_PRV    = 3'b001,
    PROT_D_NS_USR = 3'b010,
    PROT_D_NS_PRV = 3'b011,
    PROT_I_USR    = 3'b100,
    PROT_I_PRV    = 3'b101,
    PROT_I_NS_USR = 3'b110,
    PROT_I_NS_PRV = 3'b111
  } biu_prot_t;

  function automatic logic [4:0] biu_beats(biu_type_t t, logic [3:0] len);
    case (t)
      INCR:           return 5'(len) + 5'd1;
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  function automatic logic [7:0] biu_size_bytes(biu_size_t s);
    return 8'd1 << s;
  endfunction

  function automatic logic biu_is_wrap(biu_type_t t);
    return (t == WRAP4) || (t == WRAP8) || (t == WRAP16);
  endfunction

endpackage

// File: rtl/biu_next_adr.sv
// Combinational next-beat address for INCR and WRAP bursts; also used by the
// bus master for address-phase prediction.
module biu_next_adr
  import biu_burst_addrgen_pkg::*;
#(
  parameter int unsigned PLEN = 32
) (
  input  logic [PLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  biu_type_t       type_i,
  output logic [PLEN-1:0] next_adr_o
);

  logic [PLEN-1:0] incr;
  logic [PLEN-1:0] wrap_mask;
  logic [PLEN-1:0] sum;

  always_comb begin
    incr       = PLEN'(biu_size_bytes(size_i));
    // Wrap window is beats*bytes, always a power of two
    wrap_mask  = (PLEN'(biu_beats(type_i, 4'd0)) << size_i) - PLEN'(1);
    sum        = adr_i + incr;
    next_adr_o = biu_is_wrap(type_i) ? ((adr_i & ~wrap_mask) | (sum & wrap_mask)) : sum;
  end

endmodule

// File: rtl/biu_burst_addrgen.sv
// Burst sequencer: accepts one BIU burst request and emits one registered beat
// descriptor per handshake. Optional misalignment rejection via BIU_ALIGN_CHECK_EN.
module biu_burst_addrgen
  import biu_burst_addrgen_pkg::*;
#(
  parameter int unsigned PLEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [PLEN-1:0] req_adr_i,
  input  biu_size_t       req_size_i,
  input  biu_type_t       req_type_i,
  input  logic [3:0]      req_len_i,
  input  biu_prot_t       req_prot_i,
  input  logic            req_we_i,
  output logic            beat_valid_o,
  input  logic            beat_ready_i,
  output logic [PLEN-1:0] beat_adr_o,
  output biu_size_t       beat_size_o,
  output biu_type_t       beat_type_o,
  output biu_prot_t       beat_prot_o,
  output logic            beat_we_o,
  output logic            beat_first_o,
  output logic            beat_last_o,
  output logic            err_o
);

  if (XLEN < 8 || (XLEN % 8) != 0) begin : g_xlen_check
    $error("XLEN must be a non-zero multiple of 8");
  end

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [PLEN-1:0] adr_q, adr_d;
  biu_size_t       size_q, size_d;
  biu_type_t       type_q, type_d;
  biu_prot_t       prot_q, prot_d;
  logic            we_q, we_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            take;
  logic            accept;
  logic [4:0]      req_beats;
  logic [PLEN-1:0] off_mask;
  logic [PLEN-1:0] start_adr;
  logic [PLEN-1:0] next_adr;

  biu_next_adr #(
    .PLEN(PLEN)
  ) u_next_adr (
    .adr_i     (adr_q),
    .size_i    (size_q),
    .type_i    (type_q),
    .next_adr_o(next_adr)
  );

  assign take        = valid_q & beat_ready_i;
  assign req_ready_o = (state_q == StIdle) | (take & last_q);
  assign accept      = req_valid_i & req_ready_o;
  assign req_beats   = biu_beats(req_type_i, req_len_i);
  assign off_mask    = PLEN'(biu_size_bytes(req_size_i)) - PLEN'(1);
  assign start_adr   = req_adr_i & ~off_mask;

`ifdef BIU_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q, err_d;
  assign misaligned = |(req_adr_i & off_mask);
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    adr_d   = adr_q;
    size_d  = size_q;
    type_d  = type_q;
    prot_d  = prot_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
`ifdef BIU_ALIGN_CHECK_EN
    err_d   = 1'b0;
`endif

    if (take) begin
      first_d = 1'b0;
      if (cnt_q == 4'd0) begin
        state_d = StIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        adr_d  = next_adr;
        cnt_d  = cnt_q - 4'd1;
        last_d = (cnt_q == 4'd1);
      end
    end

    // A request taken alongside the last beat overrides the return to idle
    if (accept) begin
`ifdef BIU_ALIGN_CHECK_EN
      if (misaligned) begin
        state_d = StIdle;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b1;
      end else
`endif
      begin
        state_d = StBurst;
        valid_d = 1'b1;
        first_d = 1'b1;
        last_d  = (req_beats == 5'd1);
        adr_d   = start_adr;
        size_d  = req_size_i;
        type_d  = req_type_i;
        prot_d  = req_prot_i;
        we_d    = req_we_i;
        cnt_d   = 4'(req_beats - 5'd1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      adr_q   <= '0;
      size_q  <= BYTE;
      type_q  <= SINGLE;
      prot_q  <= PROT_D_USR;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      size_q  <= size_d;
      type_q  <= type_d;
      prot_q  <= prot_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIU_ALIGN_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  assign beat_valid_o = valid_q;
  assign beat_first_o = first_q;
  assign beat_last_o  = last_q;
  assign beat_adr_o   = adr_q;
  assign beat_size_o  = size_q;
  assign beat_type_o  = type_q;
  assign beat_prot_o  = prot_q;
  assign beat_we_o    = we_q;

`ifndef SYNTHESIS
  a_legal_size : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && req_ready_o) |-> (req_size_i != UNDEF_SIZE));
  a_legal_type : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && req_ready_o) |-> (req_type_i != UNDEF_BURST));
`endif

endmodule

// File: tb/tb_biu_burst_addrgen.sv
// Scoreboard bench for biu_burst_addrgen: directed bursts plus random traffic
// against an arithmetic model of INCR/WRAP sequences.
module tb_biu_burst_addrgen;
  import biu_burst_addrgen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = '0;
  biu_size_t   req_size = BYTE;
  biu_type_t   req_type = SINGLE;
  logic [3:0]  req_len = '0;
  biu_prot_t   req_prot = PROT_D_USR;
  logic        req_we = 1'b0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [31:0] beat_adr;
  biu_size_t   beat_size;
  biu_type_t   beat_type;
  biu_prot_t   beat_prot;
  logic        beat_we;
  logic        beat_first;
  logic        beat_last;
  logic        err;

  biu_burst_addrgen #(
    .PLEN(32),
    .XLEN(32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_adr_i   (req_adr),
    .req_size_i  (req_size),
    .req_type_i  (req_type),
    .req_len_i   (req_len),
    .req_prot_i  (req_prot),
    .req_we_i    (req_we),
    .beat_valid_o(beat_valid),
    .beat_ready_i(beat_ready),
    .beat_adr_o  (beat_adr),
    .beat_size_o (beat_size),
    .beat_type_o (beat_type),
    .beat_prot_o (beat_prot),
    .beat_we_o   (beat_we),
    .beat_first_o(beat_first),
    .beat_last_o (beat_last),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        first;
    logic        last;
    biu_size_t   size;
    biu_type_t   btype;
    biu_prot_t   prot;
    logic        we;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] obs_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          err_cyc = -1;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: beat n of a burst is start + n*incr, folded into the wrap window for WRAP
  task automatic model_push(input logic [31:0] adr, input biu_size_t sz, input biu_type_t ty,
                            input logic [3:0] len, input biu_prot_t pr, input logic we);
    longint unsigned incr, n, start, win, base, a;
    beat_t b;
    incr = longint'(1) << int'(sz);
    case (ty)
      SINGLE:         n = 1;
      INCR:           n = longint'(len) + 1;
      WRAP4, INCR4:   n = 4;
      WRAP8, INCR8:   n = 8;
      default:        n = 16;
    endcase
`ifdef BIU_ALIGN_CHECK_EN
    if ((longint'(adr) % incr) != 0) begin
      err_cyc = cyc + 1;
      return;
    end
`endif
    start = longint'(adr) - (longint'(adr) % incr);
    win   = n * incr;
    base  = start - (start % win);
    for (longint unsigned i = 0; i < n; i++) begin
      if (ty == WRAP4 || ty == WRAP8 || ty == WRAP16) a = base + ((start - base + i * incr) % win);
      else a = (start + i * incr) & 64'hFFFF_FFFF;
      b.adr   = a[31:0];
      b.first = (i == 0);
      b.last  = (i == n - 1);
      b.size  = sz;
      b.btype = ty;
      b.prot  = pr;
      b.we    = we;
      exp_q.push_back(b);
    end
  endtask

  // Called and returns at posedge+1; holds the request until accepted
  task automatic issue(input logic [31:0] adr, input biu_size_t sz, input biu_type_t ty,
                       input logic [3:0] len, input biu_prot_t pr, input logic we);
    int guard = 0;
    req_valid = 1'b1;
    req_adr   = adr;
    req_size  = sz;
    req_type  = ty;
    req_len   = len;
    req_prot  = pr;
    req_we    = we;
    forever begin
      @(negedge clk);
      #1;
      if (req_ready) begin
        model_push(adr, sz, ty, len, pr, we);
        break;
      end
      guard++;
      if (guard > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: req_ready low for %0d cycles, expected acceptance", guard);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 || beat_valid) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    idle(1);
  endtask

  task automatic check_obs(input string name, input logic [31:0] exp_l[$]);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_l.size()));
    for (int i = 0; i < exp_l.size() && i < obs_q.size(); i++)
      check(name, 64'(obs_q[i]), 64'(exp_l[i]));
    obs_q.delete();
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       beat_ready = 1'b1;
      1:       beat_ready = ~beat_ready;
      default: beat_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every cycle compare flow control and the front expected beat
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!rst) begin
      check("beat_valid", 64'(beat_valid), 64'(exp_q.size() > 0));
      check("req_ready", 64'(req_ready),
            64'((exp_q.size() == 0) || (beat_ready && exp_q.size() == 1)));
      check("err", 64'(err), 64'(cyc == err_cyc));
      if (beat_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        check("beat_adr", 64'(beat_adr), 64'(e.adr));
        check("beat_first", 64'(beat_first), 64'(e.first));
        check("beat_last", 64'(beat_last), 64'(e.last));
        check("beat_size", 64'(beat_size), 64'(e.size));
        check("beat_type", 64'(beat_type), 64'(e.btype));
        check("beat_prot", 64'(beat_prot), 64'(e.prot));
        check("beat_we", 64'(beat_we), 64'(e.we));
        if (beat_ready) begin
          void'(exp_q.pop_front());
          obs_q.push_back(beat_adr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] el[$];
    idle(2);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_beat_valid", 64'(beat_valid), 64'd0);
    check("rst_beat_first", 64'(beat_first), 64'd0);
    check("rst_beat_last", 64'(beat_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_beat_adr", 64'(beat_adr), 64'd0);
    rst = 1'b0;
    idle(2);

    rdy_mode = 0;
    issue(32'h38, WORD, WRAP4, 4'd0, PROT_D_PRV, 1'b0);
    drain();
    el = {32'h38, 32'h3C, 32'h30, 32'h34};
    check_obs("wrap4_word", el);

    rdy_mode = 1;
    issue(32'h100, HWORD, INCR8, 4'd0, PROT_D_NS_USR, 1'b1);
    drain();
    el = {32'h100, 32'h102, 32'h104, 32'h106, 32'h108, 32'h10A, 32'h10C, 32'h10E};
    check_obs("incr8_hword", el);

    rdy_mode = 0;
    issue(32'h2005, BYTE, WRAP8, 4'd0, PROT_I_USR, 1'b0);
    drain();
    el = {32'h2005, 32'h2006, 32'h2007, 32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2004};
    check_obs("wrap8_byte", el);

    issue(32'h40, DWORD, SINGLE, 4'd0, PROT_D_USR, 1'b1);
    issue(32'hFFFF_FFFC, WORD, INCR, 4'd2, PROT_I_PRV, 1'b0);
    drain();
    el = {32'h40, 32'hFFFF_FFFC, 32'h0, 32'h4};
    check_obs("single_then_incr", el);

    issue(32'h102, WORD, SINGLE, 4'd0, PROT_D_USR, 1'b0);
    drain();
`ifdef BIU_ALIGN_CHECK_EN
    el = {};
`else
    el = {32'h100};
`endif
    check_obs("misaligned_word", el);

    issue(32'h1000, WORD, INCR16, 4'd0, PROT_D_USR, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_valid", 64'(beat_valid), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd1);
    check("async_rst_last", 64'(beat_last), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    el = {32'h1000, 32'h1004};
    check_obs("reset_abort", el);

    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      issue($urandom, biu_size_t'($urandom_range(0, 2)), biu_type_t'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), biu_prot_t'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    obs_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
